sample_window_buffer: RTL and testbench
=======================================

Name: sample_window_buffer

Overview:
- Upstream stage of the distributed-arithmetic FIR core.
- Accepts a ready/valid stream of input samples and maintains a TAPS-deep delay line, newest sample at index 0.
- Presents the whole window as one flat vector. For every accepted sample it issues one start/data_valid request to the DA core, then holds the window stable until the core reports computation_done.

Parameters:
- TAPS, 128, delay-line depth; must equal the DA core TAPS.
- DATA_WIDTH, 16, sample width in bits (two's complement).
- CNT_WIDTH, 8, width of the internal fill counter; must satisfy 2^CNT_WIDTH > TAPS.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample this cycle.
- data_samples  out  TAPS*DATA_WIDTH  window; slice [i*DATA_WIDTH +: DATA_WIDTH] holds x[n-i].
- data_valid  out  1  window is stable and owned by the DA core.
- start  out  1  one-cycle request pulse to the DA core.
- computation_done  in  1  one-cycle completion pulse from the DA core.
- window_full  out  1  TAPS samples accepted since reset/flush.
- busy  out  1  a request is outstanding (ISSUE or WAIT).

Behaviour:
- Reset (rst=1 at clk edge), regardless of state:
  - state=IDLE; delay line all zeros; fill count 0.
  - in_ready=1, start=0, data_valid=0, window_full=0, busy=0.
  - Reset mid-request abandons it; a later stray computation_done is ignored.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: shift the delay line (x[i] <= x[i-1]; x[0] <= in_data; the oldest sample is dropped), increment fill count (saturating at TAPS), go to ISSUE.
- ISSUE (exactly one cycle):
  - start=1, data_valid=1, in_ready=0; go to WAIT.
  - start is asserted in the cycle after the accepting edge, so the window is already updated when start is seen.
- WAIT:
  - data_valid=1, start=0, in_ready=0.
  - On computation_done=1, go to IDLE. in_ready returns to 1 in the next cycle; no same-cycle bypass.
- computation_done in IDLE or ISSUE: ignored, no state change.
- in_valid while in_ready=0: stalled. in_data is not sampled; the upstream must hold it.
- data_samples must not change while data_valid=1; it changes only on an accepting edge, reset, or flush.
- busy = (state != IDLE).
- window_full = (fill count == TAPS); a registered output.
- Throughput: one sample per (DA latency + 2) cycles. Back-to-back samples never overlap requests.
- Zero-initialised history: the first TAPS outputs correspond to a filter starting from rest; no priming wait.

Optional Feature:
- Macro SAMPLE_WINDOW_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush=1 in IDLE: zero the delay line and fill count next cycle; in_ready=0 during the flush cycle; no start is issued.
  - flush in ISSUE/WAIT: latched and applied on return to IDLE, before the next sample is accepted.
  - flush together with in_valid in IDLE: flush wins and the sample is not accepted.
- Undefined: no flush port; history is cleared only by rst.

Decomposition:
- Package fir_pkg holds:
  - DATA_WIDTH and TAPS defaults, shared with the DA core.
  - The state enum {IDLE, ISSUE, WAIT}.
  - A function computing the bit-slice offset for a tap index.
- Sub-module sample_delay_line:
  - Parameterised shift register with shift_en, din, clear, and the flat vector output.
  - The FSM, handshakes and fill counter stay in sample_window_buffer.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles → in_ready=1, start=0, data_valid=0, data_samples all zero, window_full=0.
- Single sample: in_data=16'h1234 with in_valid for one cycle → start=1 exactly one cycle later; slice 0=16'h1234, others 0; data_valid stays 1 until computation_done pulsed 20 cycles later; in_ready=1 one cycle after that.
- Ordering and fill: feed 1..130, with the model DA returning computation_done 5 cycles after start:
  - window_full rises after sample 128 is accepted.
  - After 130 samples: slice 0=130, slice 127=3.
  - Exactly 130 start pulses.
- Stall: hold in_valid=1 with changing in_data while in WAIT → no sample accepted, data_samples unchanged; the held sample is accepted on the first IDLE cycle.
- Spurious done and mid-operation reset: pulse computation_done in IDLE → no effect. Assert rst during WAIT → next cycle IDLE, window zero, in_ready=1.
- SAMPLE_WINDOW_FLUSH_EN: load 10 samples, assert flush during WAIT, then pulse done → window zeroes before the next accept; the next sample gives slice 0=new value, slices 1..127=0.

Source files
------------

// File: rtl/sample_window_buffer_pkg.sv
// Shared definitions for the FIR front end: default sizes, the request FSM
// states and the tap slice helper used wherever the flat window is indexed.
package fir_pkg;

  localparam int FIR_TAPS       = 128;
  localparam int FIR_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  function automatic int tap_offset(input int tap, input int width);
    return tap * width;
  endfunction

endpackage

// File: rtl/sample_window_buffer_if.sv
// Stream-in / window-out bundle between the sample source, the window buffer
// and the DA core. The buffer uses the slave modport.
interface sample_window_buffer_if
  import fir_pkg::*;
#(
  parameter int TAPS       = FIR_TAPS,
  parameter int DATA_WIDTH = FIR_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0]      in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [TAPS*DATA_WIDTH-1:0] data_samples;
  logic                       data_valid;
  logic                       start;
  logic                       computation_done;
  logic                       window_full;
  logic                       busy;

  modport slave (
    input  in_data, in_valid, computation_done,
    output in_ready, data_samples, data_valid, start, window_full, busy
  );

  modport master (
    output in_data, in_valid, computation_done,
    input  in_ready, data_samples, data_valid, start, window_full, busy
  );

endinterface

// File: rtl/sample_window_buffer_delay_line.sv
// TAPS-deep sample shift register; tap 0 (lowest slice) holds the newest sample.
module sample_delay_line
  import fir_pkg::*;
#(
  parameter int TAPS       = FIR_TAPS,
  parameter int DATA_WIDTH = FIR_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift_en_i,
  input  logic                       clear_i,
  input  logic [DATA_WIDTH-1:0]      din_i,
  output logic [TAPS*DATA_WIDTH-1:0] samples_o
);

  logic [TAPS*DATA_WIDTH-1:0] line_q, line_d;

  // Clear takes priority so a flush can never be mixed with a shift.
  always_comb begin
    line_d = line_q;
    if (clear_i) begin
      line_d = '0;
    end else if (shift_en_i) begin
      line_d = {line_q[(TAPS-1)*DATA_WIDTH-1:0], din_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign samples_o = line_q;

endmodule

// File: rtl/sample_window_buffer.sv
// Window buffer in front of the DA FIR core: one start request per accepted
// sample, window frozen until computation_done. `SAMPLE_WINDOW_FLUSH_EN adds a flush input.
module sample_window_buffer
  import fir_pkg::*;
#(
  parameter int TAPS       = FIR_TAPS,
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int CNT_WIDTH  = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef SAMPLE_WINDOW_FLUSH_EN
  input  logic flush,
`endif
  sample_window_buffer_if.slave bus
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] fill_q, fill_d;
  logic                 full_q;
  logic                 flush_pend_q, flush_pend_d;
  logic                 flush_in;
  logic                 clear_now;
  logic                 accept;
  logic                 ready_c, start_c, valid_c, busy_c;

`ifdef SAMPLE_WINDOW_FLUSH_EN
  assign flush_in = flush;
`else
  assign flush_in = 1'b0;
`endif

  // A pending or live flush is serviced in IDLE before any new sample.
  assign clear_now = (state_q == IDLE) && (flush_in || flush_pend_q);
  assign accept    = ready_c && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.computation_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_c = 1'b0;
    start_c = 1'b0;
    valid_c = 1'b0;
    busy_c  = (state_q != IDLE);
    case (state_q)
      IDLE:  ready_c = !flush_in && !flush_pend_q;
      ISSUE: begin
        start_c = 1'b1;
        valid_c = 1'b1;
      end
      WAIT:    valid_c = 1'b1;
      default: ;
    endcase
  end

  // Fill counter saturates at TAPS; flush requests seen mid-request are parked.
  always_comb begin
    fill_d       = fill_q;
    flush_pend_d = flush_pend_q;
    if (clear_now) begin
      fill_d       = '0;
      flush_pend_d = 1'b0;
    end else if (accept && (fill_q != CNT_WIDTH'(TAPS))) begin
      fill_d = fill_q + 1'b1;
    end
    if ((state_q != IDLE) && flush_in) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q       <= '0;
      full_q       <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      fill_q       <= fill_d;
      full_q       <= (fill_d == CNT_WIDTH'(TAPS));
      flush_pend_q <= flush_pend_d;
    end
  end

  sample_delay_line #(
    .TAPS       (TAPS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_delay_line (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (accept),
    .clear_i    (clear_now),
    .din_i      (bus.in_data),
    .samples_o  (bus.data_samples)
  );

  assign bus.in_ready    = ready_c;
  assign bus.start       = start_c;
  assign bus.data_valid  = valid_c;
  assign bus.busy        = busy_c;
  assign bus.window_full = full_q;

endmodule

// File: tb/tb_sample_window_buffer.sv
// Self-checking bench for sample_window_buffer: sample-history queue model plus
// a simple DA responder. Define SAMPLE_WINDOW_FLUSH_EN to exercise flush.
module tb_sample_window_buffer;
  import fir_pkg::*;

  localparam int TAPS = FIR_TAPS;
  localparam int DW   = FIR_DATA_WIDTH;

  logic clk = 1'b0;
  logic rst;
`ifdef SAMPLE_WINDOW_FLUSH_EN
  logic flush;
`endif

  always #5 clk = ~clk;

  sample_window_buffer_if #(.TAPS(TAPS), .DATA_WIDTH(DW)) bus ();

  sample_window_buffer #(
    .TAPS       (TAPS),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef SAMPLE_WINDOW_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  // Reference model: accepted-sample history (newest first) and request bookkeeping.
  logic [DW-1:0] hist[$];
  bit  pending;
  int  age;
  bit  flushPend;
  int  cycleNo;
  int  doneCycle;
  int  daDelay;
  bit  lastAccepted;
  int  dutStarts;
  int  checks;
  int  errors;

  function automatic logic [TAPS*DW-1:0] modelWindow();
    logic [TAPS*DW-1:0] w;
    w = '0;
    for (int i = 0; i < hist.size(); i++) w[tap_offset(i, DW) +: DW] = hist[i];
    return w;
  endfunction

  task automatic checkOutput(input bit f);
    logic [TAPS*DW-1:0] expW;
    int bad;
    expW = modelWindow();
    checks++;
    assert (bus.in_ready === (!pending && !f && !flushPend)) else begin
      errors++;
      $error("[TB] FAIL in_ready cycle %0d: observed %b expected %b", cycleNo, bus.in_ready, !pending && !f && !flushPend);
    end
    checks++;
    assert (bus.start === (pending && age == 0)) else begin
      errors++;
      $error("[TB] FAIL start cycle %0d: observed %b expected %b", cycleNo, bus.start, pending && age == 0);
    end
    checks++;
    assert (bus.data_valid === pending) else begin
      errors++;
      $error("[TB] FAIL data_valid cycle %0d: observed %b expected %b", cycleNo, bus.data_valid, pending);
    end
    checks++;
    assert (bus.busy === pending) else begin
      errors++;
      $error("[TB] FAIL busy cycle %0d: observed %b expected %b", cycleNo, bus.busy, pending);
    end
    checks++;
    assert (bus.window_full === (hist.size() == TAPS)) else begin
      errors++;
      $error("[TB] FAIL window_full cycle %0d: observed %b expected %b", cycleNo, bus.window_full, hist.size() == TAPS);
    end
    checks++;
    assert (bus.data_samples === expW) else begin
      errors++;
      bad = 0;
      for (int i = TAPS - 1; i >= 0; i--)
        if (bus.data_samples[tap_offset(i, DW) +: DW] !== expW[tap_offset(i, DW) +: DW]) bad = i;
      $error("[TB] FAIL window cycle %0d slice %0d: observed %h expected %h", cycleNo, bad,
             bus.data_samples[tap_offset(bad, DW) +: DW], expW[tap_offset(bad, DW) +: DW]);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, clock, advance the model.
  task automatic applyStimulus(input bit r, input bit v, input logic [DW-1:0] d, input bit f, input bit spur);
    rst                  = r;
    bus.in_valid         = v;
    bus.in_data          = d;
    bus.computation_done = (cycleNo == doneCycle) || spur;
`ifdef SAMPLE_WINDOW_FLUSH_EN
    flush = f;
`endif
    #1;
    checkOutput(f);
    if (bus.start === 1'b1) dutStarts++;
    if (pending && age == 0) doneCycle = cycleNo + daDelay;
    lastAccepted = 1'b0;
    @(posedge clk);
    if (r) begin
      hist.delete();
      pending   = 1'b0;
      flushPend = 1'b0;
    end else if (!pending) begin
      if (f || flushPend) begin
        hist.delete();
        flushPend = 1'b0;
      end else if (v) begin
        hist.push_front(d);
        if (hist.size() > TAPS) void'(hist.pop_back());
        pending      = 1'b1;
        age          = 0;
        lastAccepted = 1'b1;
      end
    end else begin
      if (f) flushPend = 1'b1;
      if (age >= 1 && bus.computation_done) pending = 1'b0;
      age++;
    end
    cycleNo++;
    #1;
  endtask

  initial begin
    logic [DW-1:0] nextVal;
    logic [TAPS*DW-1:0] expW;
    checks    = 0;
    errors    = 0;
    cycleNo   = 0;
    doneCycle = -1;
    daDelay   = 20;
    pending   = 1'b0;
    age       = 0;
    flushPend = 1'b0;
    dutStarts = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.computation_done = 1'b0;
`ifdef SAMPLE_WINDOW_FLUSH_EN
    flush = 1'b0;
`endif
    #2;

    $display("[TB] reset and idle");
    applyStimulus(1, 0, '0, 0, 0);
    applyStimulus(1, 0, '0, 0, 0);
    applyStimulus(0, 0, '0, 0, 0);

    $display("[TB] single sample, done 20 cycles after start");
    applyStimulus(0, 1, 16'h1234, 0, 0);
    for (int c = 0; c < 26; c++) applyStimulus(0, 0, DW'($urandom), 0, 0);
    checks++;
    assert (bus.data_samples[DW-1:0] === 16'h1234) else begin
      errors++;
      $error("[TB] FAIL single_slice0: observed %h expected %h", bus.data_samples[DW-1:0], 16'h1234);
    end

    $display("[TB] ordering and fill with samples 1..130");
    applyStimulus(1, 0, '0, 0, 0);
    daDelay   = 5;
    dutStarts = 0;
    nextVal   = 1;
    for (int c = 0; c < 3000 && nextVal <= 130; c++) begin
      applyStimulus(0, 1, nextVal, 0, 0);
      if (lastAccepted) nextVal++;
    end
    for (int c = 0; c < 10; c++) applyStimulus(0, 0, '0, 0, 0);
    checks++;
    assert (nextVal === 16'd131) else begin
      errors++;
      $error("[TB] FAIL fill_accepts: observed %0d expected %0d", nextVal - 1, 130);
    end
    checks++;
    assert (dutStarts === 130) else begin
      errors++;
      $error("[TB] FAIL start_count: observed %0d expected %0d", dutStarts, 130);
    end
    checks++;
    assert (bus.data_samples[tap_offset(0, DW) +: DW] === 16'd130) else begin
      errors++;
      $error("[TB] FAIL fill_slice0: observed %0d expected %0d", bus.data_samples[tap_offset(0, DW) +: DW], 130);
    end
    checks++;
    assert (bus.data_samples[tap_offset(TAPS - 1, DW) +: DW] === 16'd3) else begin
      errors++;
      $error("[TB] FAIL fill_slice127: observed %0d expected %0d", bus.data_samples[tap_offset(TAPS - 1, DW) +: DW], 3);
    end

    $display("[TB] randomized traffic with stalls and spurious done");
    for (int c = 0; c < 400; c++) begin
      daDelay = $urandom_range(1, 8);
      applyStimulus(0, 1'($urandom_range(0, 1)), DW'($urandom), 0, !pending && ($urandom_range(0, 7) == 0));
    end

    $display("[TB] reset during WAIT");
    daDelay = 10;
    for (int c = 0; c < 50 && !(pending && age >= 1); c++) applyStimulus(0, 1, DW'($urandom), 0, 0);
    checks++;
    assert (pending && age >= 1) else begin
      errors++;
      $error("[TB] FAIL reach_wait: observed %b expected %b", pending, 1'b1);
    end
    applyStimulus(1, 0, '0, 0, 0);
    checks++;
    assert (bus.in_ready === 1'b1) else begin
      errors++;
      $error("[TB] FAIL rst_ready: observed %b expected %b", bus.in_ready, 1'b1);
    end
    for (int c = 0; c < 15; c++) applyStimulus(0, 0, DW'($urandom), 0, 0);

`ifdef SAMPLE_WINDOW_FLUSH_EN
    $display("[TB] flush during WAIT");
    daDelay = 4;
    nextVal = 16'h0101;
    for (int c = 0; c < 200 && nextVal < 16'h010B; c++) begin
      applyStimulus(0, 1, nextVal, 0, 0);
      if (lastAccepted) nextVal++;
    end
    for (int c = 0; c < 30 && !(pending && age >= 1); c++) applyStimulus(0, 0, '0, 0, 0);
    applyStimulus(0, 0, '0, 1, 0);
    for (int c = 0; c < 30 && pending; c++) applyStimulus(0, 1, 16'hBEEF, 0, 0);
    for (int c = 0; c < 30 && !lastAccepted; c++) applyStimulus(0, 1, 16'hBEEF, 0, 0);
    for (int c = 0; c < 10; c++) applyStimulus(0, 0, '0, 0, 0);
    expW = '0;
    expW[DW-1:0] = 16'hBEEF;
    checks++;
    assert (bus.data_samples === expW) else begin
      errors++;
      $error("[TB] FAIL flush_window: observed slice0 %h expected %h (slices 1..127 zero)", bus.data_samples[DW-1:0], 16'hBEEF);
    end
    $display("[TB] flush together with in_valid in IDLE");
    applyStimulus(0, 1, 16'h5555, 1, 0);
    for (int c = 0; c < 5; c++) applyStimulus(0, 0, '0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
